// File: rtl/arb_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux_pkg
//  Description : Shared defaults and the ceil-log2 helper used to size the
//                channel index of the arbitrated multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_mux_pkg;

  localparam int DEFAULT_BITWIDTH   = 8;
  localparam int DEFAULT_NUM_INPUTS = 4;

  // Smallest r such that 2**r >= value (value >= 2 in practice).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant. Searches upward from ptr,
//                wrapping at NUM_INPUTS-1; a held lock restricts the grant
//                to lock_idx only.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int SEL_W      = 2
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [SEL_W-1:0]      ptr,
  input  logic                  lock,
  input  logic [SEL_W-1:0]      lock_idx,
  output logic [NUM_INPUTS-1:0] grant,
  output logic [SEL_W-1:0]      grant_idx,
  output logic                  grant_valid
);

  int               idx;
  logic [SEL_W-1:0] idx_s;

  // Pick the first requester at or after ptr; the loop runs downward so the
  // closest candidate is the last one written and therefore wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    idx_s       = '0;
    if (lock) begin
      if (req[lock_idx]) begin
        grant_idx   = lock_idx;
        grant_valid = 1'b1;
      end
    end else begin
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
        idx_s = SEL_W'(idx);
        if (req[idx_s]) begin
          grant_idx   = idx_s;
          grant_valid = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      grant[i] = grant_valid && (grant_idx == SEL_W'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux
//  Description : Round-robin N:1 stream multiplexer with a one-deep registered
//                output stage. Optional packet locking is enabled by defining
//                the macro ARB_MUX_LOCK_EN (adds in_last/out_last).
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int BITWIDTH   = DEFAULT_BITWIDTH,
  parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS,
  parameter int SEL_W      = clog2(NUM_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_INPUTS*BITWIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]          in_valid,
  output logic [NUM_INPUTS-1:0]          in_ready,
`ifdef ARB_MUX_LOCK_EN
  input  logic [NUM_INPUTS-1:0]          in_last,
  output logic                           out_last,
`endif
  output logic [BITWIDTH-1:0]            out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SEL_W-1:0]               out_sel
);

  logic                  load;
  logic                  xfer;
  logic [SEL_W-1:0]      ptr;
  logic                  lock;
  logic [SEL_W-1:0]      lock_idx;
  logic                  beat_last;
  logic [NUM_INPUTS-1:0] grant;
  logic [SEL_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic [SEL_W-1:0]      ptr_next;

  // Output register may take a new beat when empty or being drained.
  assign load     = !out_valid || out_ready;
  assign in_ready = (load && !rst) ? grant : '0;
  assign xfer     = load && !rst && grant_valid;
  assign ptr_next = (grant_idx == SEL_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;

`ifdef ARB_MUX_LOCK_EN
  assign beat_last = in_last[grant_idx];

  // Lock tracks an open packet; it is set by a non-final beat and cleared by the final one.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock     <= 1'b0;
      lock_idx <= '0;
      out_last <= 1'b0;
    end else if (xfer) begin
      lock     <= !beat_last;
      lock_idx <= grant_idx;
      out_last <= beat_last;
    end
  end
`else
  // Without packet locking every beat is its own packet.
  assign beat_last = 1'b1;
  assign lock      = 1'b0;
  assign lock_idx  = '0;
`endif

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .SEL_W      (SEL_W)
  ) u_rr_arbiter (
    .req         (in_valid),
    .ptr         (ptr),
    .lock        (lock),
    .lock_idx    (lock_idx),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Output stage and round-robin pointer; ptr moves past a channel only when its packet ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_idx*BITWIDTH +: BITWIDTH];
      out_sel   <= grant_idx;
      if (beat_last) ptr <= ptr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_mux
//  Description : Self-checking bench for arb_mux with a behavioural reference
//                model; also exercises a 3-input, 16-bit instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_mux;

  localparam int N  = 4;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*BW-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N-1:0]  in_last;
  logic          out_last;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_sel;

  logic [47:0]   d3_data;
  logic [2:0]    d3_valid;
  logic [2:0]    d3_ready;
  logic [2:0]    d3_last;
  logic          d3_out_last;
  logic [15:0]   d3_out_data;
  logic          d3_out_valid;
  logic          d3_out_ready;
  logic [1:0]    d3_out_sel;

  int tests = 0;
  int fails = 0;

  // reference model state
  int          m_ptr;
  bit          m_valid;
  logic [BW-1:0] m_data;
  int          m_sel;
  bit          m_last;
  bit          m_lock;
  int          m_lidx;
  bit          lock_mode;

  always #5 clk = ~clk;

  arb_mux dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef ARB_MUX_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  arb_mux #(.BITWIDTH(16), .NUM_INPUTS(3), .SEL_W(2)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (d3_data),
    .in_valid  (d3_valid),
    .in_ready  (d3_ready),
`ifdef ARB_MUX_LOCK_EN
    .in_last   (d3_last),
    .out_last  (d3_out_last),
`endif
    .out_data  (d3_out_data),
    .out_valid (d3_out_valid),
    .out_ready (d3_out_ready),
    .out_sel   (d3_out_sel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Which channel the specification says wins this cycle, or -1 for none.
  function automatic int exp_grant();
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
    if (m_lock) return in_valid[m_lidx] ? m_lidx : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: inputs already driven; checks in_ready, advances, checks outputs.
  task automatic cycle();
    int g;
    logic [N-1:0] er;
    bit lst;
    #1;
    g  = exp_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0; m_lock = 0; m_last = 0;
    end else if (g >= 0) begin
      m_valid = 1;
      m_data  = in_data[g*BW +: BW];
      m_sel   = g;
      lst     = lock_mode ? in_last[g] : 1'b1;
      m_last  = lst;
      if (lst) begin
        m_lock = 0;
        m_ptr  = (g + 1) % N;
      end else begin
        m_lock = 1;
        m_lidx = g;
      end
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_sel",   32'(out_sel),   32'(m_sel));
`ifdef ARB_MUX_LOCK_EN
    chk("out_last",  32'(out_last),  32'(m_last));
`endif
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    in_valid  = v;
    in_last   = l;
    out_ready = r;
  endtask

  initial begin
`ifdef ARB_MUX_LOCK_EN
    lock_mode = 1;
`else
    lock_mode = 0;
`endif
    m_ptr = 0; m_valid = 0; m_data = '0; m_sel = 0; m_last = 0; m_lock = 0; m_lidx = 0;
    rst = 1; in_data = '0; in_valid = '0; in_last = '1; out_ready = 1'b1;
    d3_data = '0; d3_valid = '0; d3_last = '1; d3_out_ready = 1'b1;
    @(negedge clk);

    // reset holds everything quiet even with all channels offering
    in_data = 32'h44332211;
    drive(4'b1111, 4'b1111, 1'b1);
    cycle();
    cycle();
    rst = 0;

    // all channels valid: strict rotation 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      in_data = {8'h40 + 8'(k), 8'h30 + 8'(k), 8'h20 + 8'(k), 8'h10 + 8'(k)};
      cycle();
      chk("rotation_sel", 32'(out_sel), 32'(k % 4));
    end

    // single channel 2 offering 0xA5
    in_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    drive(4'b0100, 4'b1111, 1'b1);
    cycle();
    chk("ch2_data", 32'(out_data), 32'hA5);
    chk("ch2_sel",  32'(out_sel),  32'd2);

    // downstream stall for 5 cycles, then release
    in_data = 32'h5A6B7C8D;
    drive(4'b1011, 4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("stall_data", 32'(out_data), 32'hA5);
    end
    out_ready = 1'b1;
    cycle();

    // idle with ready: output drains, data/sel retained
    drive(4'b0000, 4'b1111, 1'b1);
    cycle();
    cycle();

    // reset after building ptr=3 and (when locking) an open packet on ch3
    rst = 1; cycle(); rst = 0;
    in_data = 32'hD3C2B1A0;
    drive(4'b0100, 4'b1111, 1'b1); cycle();
    drive(4'b1000, 4'b0000, 1'b1); cycle();
    rst = 1; drive(4'b1001, 4'b1111, 1'b1); cycle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    rst = 0;
    cycle();
    chk("post_rst_sel", 32'(out_sel), 32'd0);

`ifdef ARB_MUX_LOCK_EN
    // 3-beat packet on ch1 holds off ch2 until its last beat
    rst = 1; cycle(); rst = 0;
    drive(4'b0110, 4'b0000, 1'b1); cycle();
    chk("lock_b1", 32'(out_sel), 32'd1);
    cycle();
    chk("lock_b2", 32'(out_sel), 32'd1);
    drive(4'b0110, 4'b0010, 1'b1); cycle();
    chk("lock_b3", 32'(out_sel), 32'd1);
    drive(4'b0100, 4'b0100, 1'b1); cycle();
    chk("lock_after", 32'(out_sel), 32'd2);
`endif

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 59) == 0);
      in_data  = $urandom;
      in_valid = 4'($urandom);
      in_last  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111;
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    rst = 0;
    drive(4'b0000, 4'b1111, 1'b1);

    // 3-input, 16-bit instance: wrap 0,1,2,0 and never index 3
    rst = 1; @(negedge clk); rst = 0;
    d3_data = {16'hCC02, 16'hBB01, 16'hAA00};
    d3_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("n3_valid", 32'(d3_out_valid), 32'd1);
      chk("n3_sel",   32'(d3_out_sel),   32'(k % 3));
      chk("n3_data",  32'(d3_out_data),  32'(16'hAA00 + 16'h1101 * 16'(k % 3)));
    end
    d3_valid = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter BITWIDTH, default 8: data width per channel in bits.
REQ-002 Parameter NUM_INPUTS, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter SEL_W, default 2: width of the channel index; SHALL equal ceil(log2(NUM_INPUTS)).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 in_data  input  NUM_INPUTS*BITWIDTH  channel i occupies bits [i*BITWIDTH +: BITWIDTH].
REQ-007 in_valid  input  NUM_INPUTS  channel i has a beat offered.
REQ-008 in_ready  output  NUM_INPUTS  channel i beat is accepted this cycle.
REQ-009 in_last  input  NUM_INPUTS  last beat of a packet; present only with ARB_MUX_LOCK_EN.
REQ-010 out_data  output  BITWIDTH  registered selected data.
REQ-011 out_valid  output  1  out_data holds a beat.
REQ-012 out_ready  input  1  downstream accepts the beat.
REQ-013 out_sel  output  SEL_W  index of the channel that supplied out_data.
REQ-014 out_last  output  1  registered in_last of the held beat; present only with ARB_MUX_LOCK_EN.

Function
REQ-015 Load enable: load = !out_valid || out_ready; the output register captures a beat only when load=1.
REQ-016 Grant is combinational: among channels with in_valid=1, the first found searching upward from pointer ptr, wrapping from NUM_INPUTS-1 to 0.
REQ-017 in_ready[g]=1 only when load=1 and g is the granted channel; all other in_ready bits are 0; at most one bit is ever high.
REQ-018 On a transfer (in_valid[g] && in_ready[g]): out_data<=channel g data, out_sel<=g, out_valid<=1.
REQ-019 Latency: a beat accepted at edge N appears on out_data/out_valid after edge N; throughput is one beat per cycle with out_ready held at 1.
REQ-020 With no transfer and out_ready=1, out_valid<=0; out_data and out_sel retain their last values.
REQ-021 With out_valid=1 and out_ready=0, out_data, out_sel, and out_valid SHALL remain stable, and all in_ready bits SHALL be 0.
REQ-022 ptr update: after a transfer from channel g, ptr<=(g+1) mod NUM_INPUTS; with no transfer, ptr is unchanged.
REQ-023 If no in_valid bit is set, there is no grant, ptr is unchanged, and all in_ready bits are 0.
REQ-024 Starvation bound: a channel holding in_valid=1 SHALL be served within NUM_INPUTS transfers.

Reset
REQ-025 While rst=1 at an edge: out_valid<=0, out_data<=0, out_sel<=0, ptr<=0, and lock state cleared; in_ready SHALL be all 0 during reset.
REQ-026 Reset asserted mid-packet or mid-stall SHALL discard the held beat and any lock; the first grant after reset SHALL search from channel 0.

Configuration
REQ-027 Macro ARB_MUX_LOCK_EN defined: a transfer with in_last=0 sets a lock on channel g; while locked, only g may be granted, even if other channels are valid.
REQ-028 With the lock held, ptr advances and the lock clears only on the transfer carrying in_last=1.
REQ-029 With the lock held, if in_valid[g]=0, there is no grant and the lock is kept.
REQ-030 Macro ARB_MUX_LOCK_EN undefined: the in_last and out_last ports and all lock logic are absent, and every beat is arbitrated independently.

Structure
REQ-031 Shared package arb_mux_pkg SHALL hold the default BITWIDTH and NUM_INPUTS values and the ceil-log2 helper function used to derive SEL_W.
REQ-032 Sub-module rr_arbiter (inputs: req, ptr, lock, lock_idx; output: one-hot grant plus encoded index) SHALL contain the grant logic; arb_mux SHALL hold the registers and handshake logic.

Verification
REQ-033 Reset release, in_valid=4'b1111, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, with out_data matching each channel.
REQ-034 in_valid=4'b0100 only, data 0xA5 -> in_ready=4'b0100, and one cycle later out_data=0xA5, out_sel=2, out_valid=1.
REQ-035 out_ready=0 for 5 cycles with out_valid=1 -> out_data stable and in_ready=0 for all 5 cycles; out_ready=1 -> next beat loaded the same cycle.
REQ-036 ARB_MUX_LOCK_EN defined, channel 1 sends a 3-beat packet (in_last on beat 3) while channel 2 is valid -> out_sel=1,1,1,2.
REQ-037 rst pulsed mid-packet with ptr=3 -> out_valid=0 the next cycle, lock cleared, and channels 0 and 3 both valid -> channel 0 granted first.
REQ-038 NUM_INPUTS=3, BITWIDTH=16, all channels valid -> wrap-around out_sel 0,1,2,0; index 3 is never produced.
